game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
- Sequences game_control by generating its tick_game gravity strobe and its single-cycle key_* command pulses.
- Inputs are raw held-button levels, already synchronized and debounced.
- Provides level-dependent gravity, soft-drop acceleration, left/right auto-repeat (DAS), pause, and an arbiter that guarantees at most one command strobe per clock.
- Sits between the keyboard decoder and game_control.

Parameters:
- BASE_PERIOD, 50_000_000: gravity period in clk cycles at level 0.
- LEVEL_STEP, 4_000_000: period reduction per level.
- MIN_PERIOD, 5_000_000: lower bound on the gravity period.
- SOFT_DROP_PERIOD, 2_500_000: gravity period while btn_down is held.
- DAS_DELAY, 16_000_000: hold cycles before auto-repeat starts.
- DAS_RATE, 5_000_000: cycles between auto-repeat pulses.
- LEVEL_W, 4: width of the level input.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- enable, in, 1: game running; 0 freezes the scheduler.
- game_over, in, 1: from game_control; 1 freezes and clears the scheduler.
- level, in, LEVEL_W: current level (current_level_out).
- btn_left, btn_right, btn_down, btn_rotate, btn_drop, in, 1 each: held-button levels.
- pause_req, in, 1: single-cycle pause toggle request.
- tick_game, out, 1: gravity strobe, one cycle.
- key_left, key_right, key_down, key_rotate, key_drop, out, 1 each: command strobes, one cycle.
- paused, out, 1: pause state.

Behaviour:
- Reset (rst=0, asynchronous): all outputs, counters, pending flags, edge registers and DAS FSMs clear; paused=0.
- Frozen = paused | game_over | !enable.
  - While frozen, no strobes are emitted.
  - Gravity and DAS counters hold their value.
  - Pending flags and edge registers track buttons, so no stale press fires on resume.
  - game_over additionally zeroes the gravity counter and forces paused=0.
- pause_req toggles paused when enable=1 and game_over=0; otherwise it is ignored.
- Period calculation: period = max(MIN_PERIOD, BASE_PERIOD - level*LEVEL_STEP).
  - Computed in 32-bit unsigned arithmetic; underflow saturates to MIN_PERIOD.
  - With soft drop active: eff = min(period, SOFT_DROP_PERIOD).
- Gravity counter: increments each unfrozen cycle.
  - When cnt >= eff-1: cnt<=0 and a tick request is raised.
  - A drop in eff mid-count fires on the next cycle (the >= compare handles this); there is no wrap.
- Rotate, drop, down: rising edge of the button raises a request. There is no repeat.
- Left/right each run a DAS FSM with states IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on rising edge: request raised, counter cleared.
  - DELAY -> REPEAT when counter reaches DAS_DELAY-1: request raised, counter cleared.
  - In REPEAT, a request is raised every DAS_RATE cycles.
  - Release from any state -> IDLE.
  - If btn_left and btn_right are both held, both FSMs stall: no requests, counters hold.
  - Releasing one button resumes the other from its stalled state.
- Arbiter: requests set sticky pending flags.
  - Each cycle at most one of key_* / tick_game is driven.
  - Priority: drop > rotate > left > right > down > tick.
  - The granted flag clears on the same edge its strobe is registered.
  - Losers stay pending, so latency is 1 cycle when uncontended, +1 per higher-priority pending item.
  - A new request for an already-pending item merges into it; it is not counted twice.
  - A pending key_drop clears pending left/right/down/tick, since that piece is locked.
- All outputs are registered.

Optional Feature:
- Macro SCHED_SOFTDROP_EN.
- Defined: holding btn_down selects SOFT_DROP_PERIOD as above.
- Undefined: btn_down only produces its edge-triggered key_down strobe; gravity ignores the button; parameter SOFT_DROP_PERIOD is unused.

Decomposition:
- Package sched_pkg holds:
  - enum sched_cmd_e {CMD_DROP, CMD_ROTATE, CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_TICK}, which is also the priority order;
  - das_state_e {DAS_IDLE, DAS_DELAY, DAS_REPEAT};
  - the 32-bit period type.
- Sub-module das_repeater: one FSM plus counter, with inputs btn, stall, freeze and a req output. It is instantiated for left and right.

Test Plan:
- Bench parameters: BASE_PERIOD=100, LEVEL_STEP=10, MIN_PERIOD=20, SOFT_DROP_PERIOD=5, DAS_DELAY=16, DAS_RATE=4.
- Gravity: level=0, idle -> tick_game every 100 cycles; level=3 -> every 70; level=15 -> every 20 (saturated).
- DAS: hold btn_left 40 cycles -> key_left at cycle 1, at +16, then every 4 (total 7 pulses); release -> none; both left+right held -> no pulses after the initial edges.
- Arbitration: btn_drop, btn_rotate, btn_left rise in the same cycle -> key_drop then key_rotate on consecutive cycles; left discarded by the drop flush; never two strobes high at once.
- Soft drop (SCHED_SOFTDROP_EN defined): hold btn_down at level 0 -> one key_down, then tick_game every 5 cycles; without the macro -> still every 100.
- Pause/freeze: pause_req mid-count at cnt=50 -> no strobes for 200 cycles; second pause_req -> next tick after 50 more cycles; game_over=1 -> all strobes 0, paused=0.
- Reset: assert rst=0 mid-DAS-REPEAT -> all outputs 0 asynchronously; after release with btn_left still held -> no key_left until release and re-press.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and helpers for game_tick_scheduler and its DAS sub-module.
package sched_pkg;

  typedef logic [31:0] period_t;

  // Enumeration order is also the arbitration priority (bit 0 wins).
  typedef enum logic [2:0] {
    CMD_DROP   = 3'd0,
    CMD_ROTATE = 3'd1,
    CMD_LEFT   = 3'd2,
    CMD_RIGHT  = 3'd3,
    CMD_DOWN   = 3'd4,
    CMD_TICK   = 3'd5
  } sched_cmd_e;

  typedef enum logic [1:0] {
    DAS_IDLE   = 2'd0,
    DAS_DELAY  = 2'd1,
    DAS_REPEAT = 2'd2
  } das_state_e;

  localparam int unsigned NUM_CMDS = 32'd6;
  typedef logic [NUM_CMDS-1:0] cmd_vec_t;

  // Commands made pointless once a hard drop locks the piece.
  localparam cmd_vec_t DROP_FLUSH_MASK = 6'b111100;

  function automatic cmd_vec_t pick_highest(input cmd_vec_t req);
    return req & (~req + cmd_vec_t'(1'b1));
  endfunction

  function automatic period_t gravity_period(input period_t base, input period_t step,
                                             input period_t min_p, input period_t level);
    period_t reduce;
    period_t raw;
    reduce = level * step;
    raw    = (reduce < base) ? (base - reduce) : period_t'(32'd0);
    return (raw < min_p) ? min_p : raw;
  endfunction

endpackage

// File: rtl/das_repeater.sv
// Delayed auto-shift for one direction button: a pulse on press, one after DELAY
// cycles of holding, then one every RATE cycles until release.
module das_repeater
  import sched_pkg::*;
#(
  parameter period_t DELAY = 32'd16_000_000,
  parameter period_t RATE  = 32'd5_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic stall_i,
  input  logic freeze_i,
  output logic req_o
);

  das_state_e state_q, state_d;
  period_t    cnt_q, cnt_d;
  logic       rel_q;
  logic       rise_s;

  // rel_q clears on reset so a button held through reset is not seen as a new press.
  assign rise_s = btn_i & rel_q;

  // State, counter and release-seen registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DAS_IDLE;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= ~btn_i;
    end
  end

  // Next-state and repeat request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_o   = 1'b0;
    if (!btn_i) begin
      state_d = DAS_IDLE;
      cnt_d   = '0;
    end else if (freeze_i) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      case (state_q)
        DAS_IDLE: begin
          if (rise_s) begin
            state_d = DAS_DELAY;
            cnt_d   = '0;
            req_o   = 1'b1;
          end else begin
            state_d = DAS_IDLE;
          end
        end
        DAS_DELAY: begin
          if (stall_i) begin
            cnt_d = cnt_q;
          end else if (cnt_q == DELAY - 32'd1) begin
            state_d = DAS_REPEAT;
            cnt_d   = '0;
            req_o   = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        DAS_REPEAT: begin
          if (stall_i) begin
            cnt_d = cnt_q;
          end else if (cnt_q == RATE - 32'd1) begin
            cnt_d = '0;
            req_o = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = DAS_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Gravity and command-strobe scheduler feeding game_control, one strobe per clock at most.
// Optional soft-drop gravity while btn_down is held: define SCHED_SOFTDROP_EN.
module game_tick_scheduler
  import sched_pkg::*;
#(
  parameter period_t BASE_PERIOD      = 32'd50_000_000,
  parameter period_t LEVEL_STEP       = 32'd4_000_000,
  parameter period_t MIN_PERIOD       = 32'd5_000_000,
  parameter period_t SOFT_DROP_PERIOD = 32'd2_500_000,
  parameter period_t DAS_DELAY        = 32'd16_000_000,
  parameter period_t DAS_RATE         = 32'd5_000_000,
  parameter int      LEVEL_W          = 32'd4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               game_over_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               btn_left_i,
  input  logic               btn_right_i,
  input  logic               btn_down_i,
  input  logic               btn_rotate_i,
  input  logic               btn_drop_i,
  input  logic               pause_req_i,
  output logic               tick_game_o,
  output logic               key_left_o,
  output logic               key_right_o,
  output logic               key_down_o,
  output logic               key_rotate_o,
  output logic               key_drop_o,
  output logic               paused_o
);

  logic     paused_q, paused_d;
  period_t  grav_cnt_q, grav_cnt_d;
  cmd_vec_t pend_q, pend_d;
  cmd_vec_t strobe_q, strobe_d;
  logic     rel_rot_q, rel_drop_q, rel_down_q;

  logic     frozen_s;
  logic     stall_s;
  logic     left_req_s, right_req_s;
  logic     tick_req_s;
  period_t  period_s, eff_s;
  cmd_vec_t req_s, all_s, grant_s, flush_s;

  assign frozen_s = paused_q | game_over_i | ~enable_i;
  assign stall_s  = btn_left_i & btn_right_i;
  assign period_s = gravity_period(BASE_PERIOD, LEVEL_STEP, MIN_PERIOD, period_t'(level_i));

`ifdef SCHED_SOFTDROP_EN
  // Soft drop only ever speeds gravity up.
  always_comb begin
    if (btn_down_i && (period_s > SOFT_DROP_PERIOD)) begin
      eff_s = SOFT_DROP_PERIOD;
    end else begin
      eff_s = period_s;
    end
  end
`else
  logic [31:0] unused_soft_period_s;
  assign unused_soft_period_s = SOFT_DROP_PERIOD;
  assign eff_s                = period_s;
`endif

  das_repeater #(.DELAY(DAS_DELAY), .RATE(DAS_RATE)) u_das_left (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_i    (btn_left_i),
    .stall_i  (stall_s),
    .freeze_i (frozen_s),
    .req_o    (left_req_s)
  );

  das_repeater #(.DELAY(DAS_DELAY), .RATE(DAS_RATE)) u_das_right (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_i    (btn_right_i),
    .stall_i  (stall_s),
    .freeze_i (frozen_s),
    .req_o    (right_req_s)
  );

  // Gravity counter; >= rather than == so a shrinking period fires immediately.
  always_comb begin
    grav_cnt_d = grav_cnt_q;
    tick_req_s = 1'b0;
    if (game_over_i) begin
      grav_cnt_d = '0;
    end else if (frozen_s) begin
      grav_cnt_d = grav_cnt_q;
    end else if (grav_cnt_q + 32'd1 >= eff_s) begin
      grav_cnt_d = '0;
      tick_req_s = 1'b1;
    end else begin
      grav_cnt_d = grav_cnt_q + 32'd1;
    end
  end

  // Pause toggle.
  always_comb begin
    if (game_over_i) begin
      paused_d = 1'b0;
    end else if (enable_i && pause_req_i) begin
      paused_d = ~paused_q;
    end else begin
      paused_d = paused_q;
    end
  end

  // Request collection and arbitration; while frozen everything pending is discarded.
  always_comb begin
    req_s             = '0;
    req_s[CMD_DROP]   = btn_drop_i & rel_drop_q & ~frozen_s;
    req_s[CMD_ROTATE] = btn_rotate_i & rel_rot_q & ~frozen_s;
    req_s[CMD_LEFT]   = left_req_s;
    req_s[CMD_RIGHT]  = right_req_s;
    req_s[CMD_DOWN]   = btn_down_i & rel_down_q & ~frozen_s;
    req_s[CMD_TICK]   = tick_req_s;
    all_s             = pend_q | req_s;
    grant_s           = pick_highest(all_s);
    flush_s           = grant_s[CMD_DROP] ? DROP_FLUSH_MASK : cmd_vec_t'(6'd0);
    if (frozen_s) begin
      strobe_d = '0;
      pend_d   = '0;
    end else begin
      strobe_d = grant_s;
      pend_d   = all_s & ~grant_s & ~flush_s;
    end
  end

  // State registers and registered strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paused_q   <= 1'b0;
      grav_cnt_q <= '0;
      pend_q     <= '0;
      strobe_q   <= '0;
      rel_rot_q  <= 1'b0;
      rel_drop_q <= 1'b0;
      rel_down_q <= 1'b0;
    end else begin
      paused_q   <= paused_d;
      grav_cnt_q <= grav_cnt_d;
      pend_q     <= pend_d;
      strobe_q   <= strobe_d;
      rel_rot_q  <= ~btn_rotate_i;
      rel_drop_q <= ~btn_drop_i;
      rel_down_q <= ~btn_down_i;
    end
  end

  assign tick_game_o  = strobe_q[CMD_TICK];
  assign key_left_o   = strobe_q[CMD_LEFT];
  assign key_right_o  = strobe_q[CMD_RIGHT];
  assign key_down_o   = strobe_q[CMD_DOWN];
  assign key_rotate_o = strobe_q[CMD_ROTATE];
  assign key_drop_o   = strobe_q[CMD_DROP];
  assign paused_o     = paused_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: behavioural model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_game_tick_scheduler;

  localparam int BASE = 100, STEP = 10, MINP = 20, SOFT = 5, DDELAY = 16, DRATE = 4;
`ifdef SCHED_SOFTDROP_EN
  localparam int EXP_SOFT_IVL = 5;
`else
  localparam int EXP_SOFT_IVL = 100;
`endif
  // Output vector layout: {paused, tick, down, right, left, rotate, drop}
  localparam logic [6:0] M_DROP = 7'b0000001, M_ROT = 7'b0000010, M_LEFT = 7'b0000100,
                         M_RIGHT = 7'b0001000, M_DOWN = 7'b0010000, M_STROBES = 7'b0111111;

  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b1, game_over = 1'b0, pause_req = 1'b0;
  logic [3:0] level = 4'd0;
  logic b_left = 1'b0, b_right = 1'b0, b_down = 1'b0, b_rot = 1'b0, b_drop = 1'b0;
  logic tick, k_left, k_right, k_down, k_rot, k_drop, paused;

  int pass_cnt = 0, total_cnt = 0, cyc = 0, rot_seen = 0;

  game_tick_scheduler #(
    .BASE_PERIOD(BASE), .LEVEL_STEP(STEP), .MIN_PERIOD(MINP),
    .SOFT_DROP_PERIOD(SOFT), .DAS_DELAY(DDELAY), .DAS_RATE(DRATE), .LEVEL_W(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .game_over_i(game_over), .level_i(level),
    .btn_left_i(b_left), .btn_right_i(b_right), .btn_down_i(b_down),
    .btn_rotate_i(b_rot), .btn_drop_i(b_drop), .pause_req_i(pause_req),
    .tick_game_o(tick), .key_left_o(k_left), .key_right_o(k_right), .key_down_o(k_down),
    .key_rotate_o(k_rot), .key_drop_o(k_drop), .paused_o(paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [6:0] act_vec();
    return {paused, tick, k_down, k_right, k_left, k_rot, k_drop};
  endfunction

  // ---------------- behavioural model ----------------
  // Commands indexed by priority: 0 drop, 1 rotate, 2 left, 3 right, 4 down, 5 tick.
  bit         m_paused;
  int         m_elapsed;
  bit         m_pend [6];
  bit         m_arm_drop, m_arm_rot, m_arm_down;
  bit         m_das_arm [2];
  bit         m_das_act [2];
  int         m_das_held [2];
  logic [6:0] exp_out = 7'd0;

  task automatic model_reset();
    m_paused = 0; m_elapsed = 0;
    m_arm_drop = 0; m_arm_rot = 0; m_arm_down = 0;
    for (int i = 0; i < 6; i++) m_pend[i] = 0;
    for (int s = 0; s < 2; s++) begin
      m_das_arm[s] = 0; m_das_act[s] = 0; m_das_held[s] = 0;
    end
    exp_out = 7'd0;
  endtask

  // held = unstalled, unfrozen cycles since the press; pulses at 0, DDELAY, DDELAY+k*DRATE.
  task automatic das_step(input int s, input bit b, input bit other, input bit frozen, output bit r);
    bit press;
    r = 0;
    press = b && m_das_arm[s];
    m_das_arm[s] = !b;
    if (!b) begin
      m_das_act[s] = 0; m_das_held[s] = 0;
    end else if (!frozen) begin
      if (!m_das_act[s]) begin
        if (press) begin m_das_act[s] = 1; m_das_held[s] = 0; r = 1; end
      end else if (!other) begin
        m_das_held[s]++;
        if (m_das_held[s] == DDELAY ||
            (m_das_held[s] > DDELAY && (m_das_held[s] - DDELAY) % DRATE == 0)) r = 1;
      end
    end
  endtask

  task automatic model_step();
    bit frozen;
    bit req [6];
    int period, eff, win;
    logic [5:0] strobe;
    frozen = m_paused || game_over || !enable;
    for (int i = 0; i < 6; i++) req[i] = 0;
    req[0] = b_drop && m_arm_drop && !frozen;
    req[1] = b_rot && m_arm_rot && !frozen;
    req[4] = b_down && m_arm_down && !frozen;
    m_arm_drop = !b_drop; m_arm_rot = !b_rot; m_arm_down = !b_down;
    das_step(0, b_left, b_right, frozen, req[2]);
    das_step(1, b_right, b_left, frozen, req[3]);
    period = BASE - int'(level) * STEP;
    if (period < MINP) period = MINP;
    eff = period;
`ifdef SCHED_SOFTDROP_EN
    if (b_down && eff > SOFT) eff = SOFT;
`endif
    if (game_over) m_elapsed = 0;
    else if (!frozen) begin
      m_elapsed++;
      if (m_elapsed >= eff) begin m_elapsed = 0; req[5] = 1; end
    end
    for (int i = 0; i < 6; i++) m_pend[i] = m_pend[i] | req[i];
    strobe = 6'd0;
    if (frozen) begin
      for (int i = 0; i < 6; i++) m_pend[i] = 0;
    end else begin
      win = -1;
      for (int i = 0; i < 6; i++) if (m_pend[i] && win < 0) win = i;
      if (win >= 0) begin
        strobe[win] = 1'b1;
        m_pend[win] = 0;
        if (win == 0) for (int i = 2; i < 6; i++) m_pend[i] = 0;
      end
    end
    if (game_over) m_paused = 0;
    else if (enable && pause_req) m_paused = !m_paused;
    exp_out = {m_paused, strobe};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle compare against the model plus the one-strobe rule.
  always @(negedge clk) begin
    logic [6:0] v;
    cyc++;
    v = act_vec();
    if (k_rot) rot_seen++;
    check("outputs_vs_model", int'(v), int'(exp_out));
    check("one_strobe", int'($countones(v[5:0]) <= 1), 1);
  end

  // ---------------- directed helpers ----------------
  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (tick) begin n = i; break; end
    end
  endtask

  task automatic measure_period(input string name, input int expected);
    int a, b;
    wait_tick(400, a);
    wait_tick(400, b);
    check(name, b, expected);
  endtask

  task automatic count_mask(input logic [6:0] mask, input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if ((act_vec() & mask) != 7'd0) n++;
    end
  endtask

  initial begin
    int n, t0;
    int times[$];
    logic [6:0] v;

    #2 rst_n = 1'b0;
    #5 check("reset_outputs", int'(act_vec()), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Gravity at three levels.
    wait_tick(400, n);
    check("first_tick_after_reset", n, 100);
    measure_period("grav_level0", 100);
    level = 4'd3;
    measure_period("grav_level3", 70);
    level = 4'd15;
    measure_period("grav_level15_sat", 20);
    @(negedge clk) level = 4'd0;

    // DAS: hold left for 40 cycles, then release.
    @(negedge clk) b_left = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (k_left) times.push_back(i);
      if (i == 40) b_left = 1'b0;
    end
    check("das_pulse_count", times.size(), 7);
    if (times.size() >= 3) begin
      check("das_first", times[0], 1);
      check("das_delay", times[1] - times[0], 16);
      check("das_rate", times[2] - times[1], 4);
    end else check("das_pulse_times", times.size(), 3);

    // Both directions held: only the two press pulses.
    @(negedge clk) begin b_left = 1'b1; b_right = 1'b1; end
    count_mask(M_LEFT | M_RIGHT, 40, n);
    check("das_both_stall", n, 2);
    b_left = 1'b0; b_right = 1'b0;
    repeat (5) @(negedge clk);

    // Arbitration with drop flush.
    b_drop = 1'b1; b_rot = 1'b1; b_left = 1'b1;
    @(negedge clk) v = act_vec();
    check("arb_drop_first", int'(v[5:0]), 1);
    @(negedge clk) v = act_vec();
    check("arb_rotate_second", int'(v[5:0]), 2);
    count_mask(M_LEFT, 8, n);
    check("arb_left_flushed", n, 0);
    b_drop = 1'b0; b_rot = 1'b0; b_left = 1'b0;
    repeat (3) @(negedge clk);

    // Soft drop.
    b_down = 1'b1;
    count_mask(M_DOWN, 30, n);
    check("softdrop_one_key_down", n, 1);
    measure_period("softdrop_interval", EXP_SOFT_IVL);
    b_down = 1'b0;
    measure_period("after_softdrop", 100);

    // Pause at cnt=50, hold 200 cycles, resume.
    wait_tick(400, n);
    repeat (50) @(negedge clk);
    pause_req = 1'b1;
    @(negedge clk) pause_req = 1'b0;
    check("paused_set", int'(paused), 1);
    count_mask(M_STROBES, 200, n);
    check("paused_no_strobes", n, 0);
    pause_req = 1'b1;
    @(negedge clk) pause_req = 1'b0;
    check("paused_cleared", int'(paused), 0);
    wait_tick(200, n);
    check("resume_remaining_count", n, 49);

    // game_over clears pause, suppresses strobes, and a press during it stays dead.
    @(negedge clk) pause_req = 1'b1;
    @(negedge clk) pause_req = 1'b0;
    game_over = 1'b1;
    @(negedge clk) check("game_over_unpauses", int'(paused), 0);
    b_rot = 1'b1;
    count_mask(M_STROBES, 150, n);
    check("game_over_no_strobes", n, 0);
    game_over = 1'b0;
    t0 = rot_seen;
    wait_tick(300, n);
    check("game_over_cnt_zeroed", n, 100);
    check("no_stale_rotate", rot_seen - t0, 0);
    b_rot = 1'b0;

    // Async reset in DAS repeat with button still held.
    @(negedge clk) b_left = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (k_left) n++;
    end
    check("das_before_reset", n, 3);
    #1 rst_n = 1'b0;
    #1 check("async_reset_clears", int'(act_vec()), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    count_mask(M_LEFT, 40, n);
    check("held_through_reset", n, 0);
    @(negedge clk) b_left = 1'b0;
    @(negedge clk) b_left = 1'b1;
    count_mask(M_LEFT, 3, n);
    check("repress_after_reset", n, 1);
    b_left = 1'b0;

    // Randomized phase checked by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) b_left = ~b_left;
      if ($urandom_range(0, 11) == 0) b_right = ~b_right;
      if ($urandom_range(0, 15) == 0) b_down = ~b_down;
      if ($urandom_range(0, 9) == 0) b_rot = ~b_rot;
      if ($urandom_range(0, 19) == 0) b_drop = ~b_drop;
      pause_req = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 199) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) enable = ~enable;
      if (game_over) game_over = ($urandom_range(0, 29) != 0);
      else game_over = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk) begin
      b_left = 1'b0; b_right = 1'b0; b_down = 1'b0; b_rot = 1'b0; b_drop = 1'b0;
      pause_req = 1'b0; enable = 1'b1; game_over = 1'b0;
    end
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
